// File: rtl/ifft16_seq.sv
// rtl/ifft16_seq.sv - sequential 16-point radix-2 DIT inverse FFT, one butterfly per cycle
// Optional per-stage 1/2 scaling (true IDFT) under `define IFFT16_STAGE_SCALE_EN.
module ifft16_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 15,
    parameter int POINT_FFT  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_re_i,
    input  logic [DATA_WIDTH-1:0] in_im_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_re_o,
    output logic [DATA_WIDTH-1:0] out_im_o,
    output logic [3:0]            out_idx_o,
    output logic                  out_last_o,
    output logic                  ovf_o
);

    if (POINT_FFT != 16) begin : g_bad_point
        $error("ifft16_seq supports POINT_FFT == 16 only");
    end

    localparam int TW_W = FRAC_BITS + 2;
    localparam int PW   = DATA_WIDTH + TW_W + 1;
    localparam int AW   = DATA_WIDTH + 3;
    localparam int RND  = 1 << (FRAC_BITS - 1);
    localparam logic signed [AW-1:0] MAX_W = AW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] MIN_W = AW'(-(1 << (DATA_WIDTH - 1)));

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] load_cnt_q, load_cnt_d;
    logic [4:0] cmp_cnt_q, cmp_cnt_d;
    logic [3:0] out_cnt_q, out_cnt_d;
    logic       ovf_q, ovf_d;
    logic       wr_load, wr_bfly;

    logic signed [DATA_WIDTH-1:0] re_q [16];
    logic signed [DATA_WIDTH-1:0] im_q [16];

    // Conjugated twiddles e^{+j*2*pi*k/16}, Q1.15 held in 17 bits so +1.0 is exact
    function automatic logic signed [TW_W-1:0] tw_re(input logic [2:0] i);
        case (i)
            3'd0:    tw_re = TW_W'(32768);
            3'd1:    tw_re = TW_W'(30274);
            3'd2:    tw_re = TW_W'(23170);
            3'd3:    tw_re = TW_W'(12540);
            3'd4:    tw_re = TW_W'(0);
            3'd5:    tw_re = TW_W'(-12540);
            3'd6:    tw_re = TW_W'(-23170);
            default: tw_re = TW_W'(-30274);
        endcase
    endfunction

    function automatic logic signed [TW_W-1:0] tw_im(input logic [2:0] i);
        case (i)
            3'd0:    tw_im = TW_W'(0);
            3'd1:    tw_im = TW_W'(12540);
            3'd2:    tw_im = TW_W'(23170);
            3'd3:    tw_im = TW_W'(30274);
            3'd4:    tw_im = TW_W'(32768);
            3'd5:    tw_im = TW_W'(30274);
            3'd6:    tw_im = TW_W'(23170);
            default: tw_im = TW_W'(12540);
        endcase
    endfunction

    function automatic logic signed [AW-1:0] stage_scale(input logic signed [AW-1:0] v);
`ifdef IFFT16_STAGE_SCALE_EN
        stage_scale = v >>> 1;
`else
        stage_scale = v;
`endif
    endfunction

    // Returns {saturated_flag, clipped_value}
    function automatic logic [DATA_WIDTH:0] sat(input logic signed [AW-1:0] v);
        if (v > MAX_W)      sat = {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (v < MIN_W) sat = {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
        else                sat = {1'b0, v[DATA_WIDTH-1:0]};
    endfunction

    logic [1:0] stg;
    logic [2:0] kk, kmask, klo, tw_idx;
    logic [3:0] half, ia, ib;

    always_comb begin
        stg    = cmp_cnt_q[4:3];
        kk     = cmp_cnt_q[2:0];
        half   = 4'd1 << stg;
        kmask  = 3'(half - 4'd1);
        klo    = kk & kmask;
        ia     = ((({1'b0, kk}) >> stg) << ({1'b0, stg} + 3'd1)) | {1'b0, klo};
        ib     = ia | half;
        tw_idx = klo << (3'd3 - {1'b0, stg});
    end

    logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im;
    logic signed [DATA_WIDTH-1:0] na_re, na_im, nb_re, nb_im;
    logic signed [TW_W-1:0]       w_re, w_im;
    logic signed [PW-1:0]         pr_re, pr_im;
    logic signed [AW-1:0]         t_re, t_im;
    logic [3:0]                   sat_f;

    always_comb begin
        a_re  = re_q[ia];
        a_im  = im_q[ia];
        b_re  = re_q[ib];
        b_im  = im_q[ib];
        w_re  = tw_re(tw_idx);
        w_im  = tw_im(tw_idx);
        pr_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
        pr_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
        t_re  = AW'((pr_re + PW'(RND)) >>> FRAC_BITS);
        t_im  = AW'((pr_im + PW'(RND)) >>> FRAC_BITS);
        {sat_f[0], na_re} = sat(stage_scale(AW'(a_re) + t_re));
        {sat_f[1], na_im} = sat(stage_scale(AW'(a_im) + t_im));
        {sat_f[2], nb_re} = sat(stage_scale(AW'(a_re) - t_re));
        {sat_f[3], nb_im} = sat(stage_scale(AW'(a_im) - t_im));
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        cmp_cnt_d  = cmp_cnt_q;
        out_cnt_d  = out_cnt_q;
        ovf_d      = ovf_q;
        wr_load    = 1'b0;
        wr_bfly    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (in_valid_i) begin
                    wr_load    = 1'b1;
                    load_cnt_d = load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'd15) begin
                        state_d   = ST_COMPUTE;
                        cmp_cnt_d = 5'd0;
                        ovf_d     = 1'b0;
                    end
                end
            end
            ST_COMPUTE: begin
                wr_bfly   = 1'b1;
                cmp_cnt_d = cmp_cnt_q + 5'd1;
                ovf_d     = ovf_q | (|sat_f);
                if (cmp_cnt_q == 5'd31) begin
                    state_d   = ST_UNLOAD;
                    out_cnt_d = 4'd0;
                end
            end
            ST_UNLOAD: begin
                if (out_ready_i) begin
                    out_cnt_d = out_cnt_q + 4'd1;
                    if (out_cnt_q == 4'd15) state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= 4'd0;
            cmp_cnt_q  <= 5'd0;
            out_cnt_q  <= 4'd0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            cmp_cnt_q  <= cmp_cnt_d;
            out_cnt_q  <= out_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Inputs land bit-reversed so the in-place DIT leaves the result in natural order
    always_ff @(posedge clk_i) begin
        if (wr_load) begin
            re_q[{load_cnt_q[0], load_cnt_q[1], load_cnt_q[2], load_cnt_q[3]}] <= in_re_i;
            im_q[{load_cnt_q[0], load_cnt_q[1], load_cnt_q[2], load_cnt_q[3]}] <= in_im_i;
        end else if (wr_bfly) begin
            re_q[ia] <= na_re;
            im_q[ia] <= na_im;
            re_q[ib] <= nb_re;
            im_q[ib] <= nb_im;
        end
    end

    assign in_ready_o  = (state_q == ST_LOAD);
    assign out_valid_o = (state_q == ST_UNLOAD);
    assign out_idx_o   = out_cnt_q;
    assign out_last_o  = (state_q == ST_UNLOAD) && (out_cnt_q == 4'd15);
    assign out_re_o    = (state_q == ST_UNLOAD) ? re_q[out_cnt_q] : '0;
    assign out_im_o    = (state_q == ST_UNLOAD) ? im_q[out_cnt_q] : '0;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_ifft16_seq.sv
// tb/tb_ifft16_seq.sv - scoreboard bench for ifft16_seq with directed frames
module tb_ifft16_seq;

`ifdef IFFT16_STAGE_SCALE_EN
    localparam bit SCALE = 1'b1;
`else
    localparam bit SCALE = 1'b0;
`endif
    localparam int IMP_AMP = SCALE ? 16384 : 1024;
    localparam int TOL_SIN = SCALE ? 2 : 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, ovf;
    logic [15:0] in_re, in_im, out_re, out_im;
    logic [3:0]  out_idx;

    always #5 clk = ~clk;

    ifft16_seq dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_re_i(in_re), .in_im_i(in_im),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_re_o(out_re), .out_im_o(out_im),
        .out_idx_o(out_idx), .out_last_o(out_last), .ovf_o(ovf)
    );

    typedef struct {
        int re;
        int im;
        int tol;
        int idx;
        bit chk_ovf;
        bit ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   xr[16];
    int   xi[16];
    int   cos_tab[16] = '{1024, 946, 724, 392, 0, -392, -724, -946,
                          -1024, -946, -724, -392, 0, 392, 724, 946};

    task automatic check(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d tol=%0d t=%0t", name, act, exp, tol, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual_idx=%0d expected=none", out_idx);
            end else begin
                e = sb_q.pop_front();
                check("out_re", int'($signed(out_re)), e.re, e.tol);
                check("out_im", int'($signed(out_im)), e.im, e.tol);
                check("out_idx", int'(out_idx), e.idx, 0);
                check("out_last", int'(out_last), int'(e.idx == 15), 0);
                if (e.chk_ovf) check("ovf_frame_end", int'(ovf), int'(e.ovf), 0);
            end
        end
    end

    task automatic clear_frame();
        for (int i = 0; i < 16; i++) begin
            xr[i] = 0;
            xi[i] = 0;
        end
    endtask

    task automatic push_exp(input int re, input int im, input int tol, input int idx, input bit ov);
        exp_t e;
        e.re = re; e.im = im; e.tol = tol; e.idx = idx;
        e.chk_ovf = (idx == 15);
        e.ovf = ov;
        sb_q.push_back(e);
    endtask

    task automatic send_frame(input bit hold_valid);
        int guard;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_re = 16'(xr[i]);
            in_im = 16'(xi[i]);
            guard = 0;
            while (!in_ready && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 100) check("load_ready_timeout", guard, 0, 0);
            @(posedge clk); #1;
        end
        if (!hold_valid) in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(posedge clk); #1;
            n++;
            if (out_valid && out_last && out_ready) in_valid = 1'b0;
            if (in_ready && !out_valid && sb_q.size() == 0) break;
        end
        if (n >= budget) check("frame_done_timeout", n, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int hr, hi, hidx;
        in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1; rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("rst_in_ready", int'(in_ready), 1, 0);
        check("rst_out_valid", int'(out_valid), 0, 0);
        check("rst_out_last", int'(out_last), 0, 0);
        check("rst_out_idx", int'(out_idx), 0, 0);
        check("rst_out_re", int'(out_re), 0, 0);
        check("rst_ovf", int'(ovf), 0, 0);
        rst_n = 1'b1;

        // Frame A: DC impulse, latency and ready timing, in_valid held high
        clear_frame();
        xr[0] = IMP_AMP;
        for (int n = 0; n < 16; n++) push_exp(1024, 0, 0, n, 1'b0);
        send_frame(1'b1);
        check("ready_low_after_last", int'(in_ready), 0, 0);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
            if (in_ready) check("ready_during_compute", 1, 0, 0);
        end
        check("latency_edges", lat, 32, 0);
        wait_done(200);

        // Frame B: X[1] tone checks the +j rotation, backpressure at idx 7
        clear_frame();
        xr[1] = IMP_AMP;
        for (int n = 0; n < 16; n++) push_exp(cos_tab[n], cos_tab[(n + 12) % 16], TOL_SIN, n, 1'b0);
        send_frame(1'b1);
        lat = 0;
        while (!(out_valid && out_idx == 4'd7) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("reach_idx7", int'(out_idx), 7, 0);
        out_ready = 1'b0;
        hr = int'(out_re); hi = int'(out_im); hidx = int'(out_idx);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_re_stable", int'(out_re), hr, 0);
            check("bp_im_stable", int'(out_im), hi, 0);
            check("bp_idx_stable", int'(out_idx), hidx, 0);
            check("bp_in_ready", int'(in_ready), 0, 0);
        end
        out_ready = 1'b1;
        wait_done(200);

        // Frame C: full-scale DC, saturates only without stage scaling
        clear_frame();
        for (int i = 0; i < 16; i++) xr[i] = 32767;
        push_exp(32767, 0, 0, 0, 1'b0);
        for (int n = 1; n < 16; n++) push_exp(0, 0, 16, n, !SCALE);
        send_frame(1'b0);
        wait_done(200);
        check("ovf_hold_in_load", int'(ovf), int'(!SCALE), 0);

        // Frame D: same data, reset asserted in compute cycle 10
        send_frame(1'b0);
        check("ovf_clear_on_compute", int'(ovf), 0, 0);
        repeat (9) @(posedge clk);
        #1;
        check("ovf_set_in_compute", int'(ovf), int'(!SCALE), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", int'(in_ready), 1, 0);
        check("midrst_out_valid", int'(out_valid), 0, 0);
        check("midrst_out_idx", int'(out_idx), 0, 0);
        check("midrst_out_im", int'(out_im), 0, 0);
        check("midrst_ovf", int'(ovf), 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Frame E: clean frame after the aborted one
        clear_frame();
        xr[0] = IMP_AMP;
        for (int n = 0; n < 16; n++) push_exp(1024, 0, 0, n, 1'b0);
        send_frame(1'b0);
        wait_done(200);
        check("sb_empty_end", sb_q.size(), 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
